pipelined_carry_select_adder: RTL and testbench

- Parametrised, pipelined carry-select adder for the ALU datapath.
- Splits each WIDTH-bit operand into NUM_BLK = WIDTH/BLOCK blocks and resolves one block per pipeline stage: both candidate block sums (carry-in 0 and 1) are formed, then one is selected by the registered carry from the previous stage.
- Full throughput of one operation per cycle, with valid/ready handshakes on the input and output sides and whole-pipeline stall on backpressure.

---
 rtl/csel_adder_pkg.sv | 30 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_carry_select_adder_csel_block.sv | 47 ++++
 rtl/pipelined_carry_select_adder.sv | 150 +++++++++++++++
 tb/tb_pipelined_carry_select_adder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/csel_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder.
// Holds the default geometry, the stage-count helper, the geometry
// legality test and the reference layout of one pipeline stage record.
package csel_adder_pkg;

  localparam int CSEL_DEF_WIDTH = 32;
  localparam int CSEL_DEF_BLOCK = 8;

  // Number of pipeline stages, one per BLOCK-wide slice of the operands.
  function automatic int csel_num_blk(input int width, input int block);
    return (block > 0) ? (width / block) : 0;
  endfunction

  // The operand width must split into a whole, non-zero number of blocks.
  function automatic bit csel_params_ok(input int width, input int block);
    return (block > 0) && (width >= block) && ((width % block) == 0);
  endfunction

  // Contents carried by one stage at the default width. Stages store only
  // the still-unresolved operand bits and the already-resolved sum bits.
  typedef struct packed {
    logic [CSEL_DEF_WIDTH-1:0] a;
    logic [CSEL_DEF_WIDTH-1:0] b;
    logic [CSEL_DEF_WIDTH-1:0] psum;
    logic                      carry;
    logic                      vld;
    logic                      sub;
  } csel_stage_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple chains of each block.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_carry_select_adder_csel_block.sv
// csel_block: combinational BLOCK-wide carry-select slice.
// Two ripple chains precompute the sum for carry-in 0 and carry-in 1;
// the real incoming carry then only drives a mux.
module csel_block
  import csel_adder_pkg::*;
#(
  parameter int BLOCK = CSEL_DEF_BLOCK
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout
);

  logic [BLOCK:0]   w_c0;
  logic [BLOCK:0]   w_c1;
  logic [BLOCK-1:0] w_sum0;
  logic [BLOCK-1:0] w_sum1;

  assign w_c0[0] = 1'b0;
  assign w_c1[0] = 1'b1;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    full_adder u_fa0 (
      .i_a   (i_a[i]),
      .i_b   (i_b[i]),
      .i_cin (w_c0[i]),
      .o_sum (w_sum0[i]),
      .o_cout(w_c0[i+1])
    );
    full_adder u_fa1 (
      .i_a   (i_a[i]),
      .i_b   (i_b[i]),
      .i_cin (w_c1[i]),
      .o_sum (w_sum1[i]),
      .o_cout(w_c1[i+1])
    );
  end

  // Pick the precomputed candidate that matches the incoming carry.
  always_comb begin
    o_sum  = i_cin ? w_sum1     : w_sum0;
    o_cout = i_cin ? w_c1[BLOCK] : w_c0[BLOCK];
  end

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: WIDTH-bit adder resolving one BLOCK-wide
// slice per pipeline stage with carry-select blocks. Valid/ready on both
// sides; backpressure stalls the whole pipeline at once.
// Optional macro CSEL_ADDER_SUB_EN adds a Sub input that turns the
// operation into A - B (B inverted, carry-in forced to 1, Cin ignored).
module pipelined_carry_select_adder
  import csel_adder_pkg::*;
#(
  parameter int WIDTH = CSEL_DEF_WIDTH,
  parameter int BLOCK = CSEL_DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef CSEL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int NUM_BLK = csel_num_blk(WIDTH, BLOCK);

  if (!csel_params_ok(WIDTH, BLOCK)) begin : g_param_err
    $error("pipelined_carry_select_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;
  logic             r_out_zero;

  // The pipeline moves as a unit whenever the output slot is free or drained.
  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = w_adv;

`ifdef CSEL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1; the inverted B is what travels down the pipe.
  assign w_b_eff   = Sub ? ~B   : B;
  assign w_cin_eff = Sub ? 1'b1 : Cin;
`else
  assign w_b_eff   = B;
  assign w_cin_eff = Cin;
`endif

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_stg
    localparam int LO = k * BLOCK;
    localparam int HI = LO + BLOCK;

    // Operand bits not yet resolved when entering this stage.
    logic [WIDTH-1:LO] w_a_src;
    logic [WIDTH-1:LO] w_b_src;
    logic              w_cin;
    logic              w_vld_in;
    logic [BLOCK-1:0]  w_blk_sum;
    logic              w_blk_cout;
    logic [HI-1:0]     w_psum;

    if (k == 0) begin : g_src
      assign w_a_src  = A;
      assign w_b_src  = w_b_eff;
      assign w_cin    = w_cin_eff;
      assign w_vld_in = in_valid;
      assign w_psum   = w_blk_sum;
    end else begin : g_src
      assign w_a_src  = g_stg[k-1].g_mid.r_a;
      assign w_b_src  = g_stg[k-1].g_mid.r_b;
      assign w_cin    = g_stg[k-1].g_mid.r_c;
      assign w_vld_in = g_stg[k-1].g_mid.r_vld;
      assign w_psum   = {w_blk_sum, g_stg[k-1].g_mid.r_psum};
    end

    csel_block #(
      .BLOCK(BLOCK)
    ) u_blk (
      .i_a   (w_a_src[LO +: BLOCK]),
      .i_b   (w_b_src[LO +: BLOCK]),
      .i_cin (w_cin),
      .o_sum (w_blk_sum),
      .o_cout(w_blk_cout)
    );

    if (k < NUM_BLK - 1) begin : g_mid
      logic [WIDTH-1:HI] r_a;
      logic [WIDTH-1:HI] r_b;
      logic [HI-1:0]     r_psum;
      logic              r_c;
      logic              r_vld;

      // Stage k boundary: keep resolved low bits and the carry, forward the rest.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld  <= 1'b0;
          r_c    <= 1'b0;
          r_a    <= '0;
          r_b    <= '0;
          r_psum <= '0;
        end else if (w_adv) begin
          r_vld <= w_vld_in;
          if (w_vld_in) begin
            r_c    <= w_blk_cout;
            r_a    <= w_a_src[WIDTH-1:HI];
            r_b    <= w_b_src[WIDTH-1:HI];
            r_psum <= w_psum;
          end
        end
      end
    end else begin : g_last
      // Final stage boundary: full sum and flags, driven straight to the ports.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_vld  <= 1'b0;
          r_out_sum  <= '0;
          r_out_cout <= 1'b0;
          r_out_ovf  <= 1'b0;
          r_out_zero <= 1'b0;
        end else if (w_adv) begin
          r_out_vld <= w_vld_in;
          if (w_vld_in) begin
            r_out_sum  <= w_psum;
            r_out_cout <= w_blk_cout;
            r_out_ovf  <= (w_a_src[WIDTH-1] == w_b_src[WIDTH-1]) &&
                          (w_psum[WIDTH-1] != w_a_src[WIDTH-1]);
            r_out_zero <= ~|w_psum;
          end
        end
      end
    end
  end

  assign out_valid = r_out_vld;
  assign Sum       = r_out_sum;
  assign Cout      = r_out_cout;
  assign Overflow  = r_out_ovf;
  assign Zero      = r_out_zero;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Directed testbench for pipelined_carry_select_adder (WIDTH=32, BLOCK=8).
// Define CSEL_ADDER_SUB_EN to also exercise the subtract mode.
module tb_pipelined_carry_select_adder;

  localparam int WIDTH = 32;
  localparam int BLOCK = 8;
  localparam int LAT   = 4;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A         = '0;
  logic [WIDTH-1:0] B         = '0;
  logic             Cin       = 1'b0;
`ifdef CSEL_ADDER_SUB_EN
  logic             Sub       = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;
  logic             Zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_carry_select_adder #(
    .WIDTH(WIDTH),
    .BLOCK(BLOCK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
`ifdef CSEL_ADDER_SUB_EN
    .Sub      (Sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow),
    .Zero     (Zero)
  );

  // Expected results packed as {Cout, Overflow, Zero, Sum}.
  logic [WIDTH-1:0] op_a [6] = '{32'h1111_1111, 32'h0000_FFFF, 32'hFFFF_FFFF,
                                 32'h7FFF_FFFF, 32'h0000_0001, 32'hAAAA_AAAA};
  logic [WIDTH-1:0] op_b [6] = '{32'h2222_2222, 32'h0000_0001, 32'h0000_0001,
                                 32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_5555};
  logic             op_c [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [34:0]      op_e [6] = '{{3'b000, 32'h3333_3333}, {3'b000, 32'h0001_0000},
                                 {3'b101, 32'h0000_0000}, {3'b010, 32'h8000_0000},
                                 {3'b101, 32'h0000_0000}, {3'b000, 32'hFFFF_FFFF}};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with out_ready high and check latency and result.
  task automatic run_one(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin,
                         input logic [34:0] exp);
    int n;
    A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, LAT);
    chk({tag, " result"}, {Cout, Overflow, Zero, Sum}, exp);
    tick();
    chk({tag, " drained"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx_in;
    int idx_out;
    int stall_left;
    bit seen;
    bit in_x;
    bit dup;
    bit stale;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset outputs", {Cout, Overflow, Zero, Sum}, 35'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("in_ready after reset", in_ready, 1'b1);

    // Single operations
    run_one("single ff+1", 32'h0000_00FF, 32'h0000_0001, 1'b0, {3'b000, 32'h0000_0100});
    run_one("carry all blocks", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {3'b101, 32'h0000_0000});
    run_one("signed overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {3'b010, 32'h8000_0000});
    run_one("neg overflow", 32'h8000_0000, 32'h8000_0000, 1'b0, {3'b111, 32'h0000_0000});
    run_one("mixed", 32'h1234_5678, 32'h8765_4321, 1'b1, {3'b000, 32'h9999_999A});

    // Back-to-back with a 3-cycle stall after the first result
    idx_in = 0; idx_out = 0; stall_left = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 40 && idx_out < 6; cyc++) begin
      if (idx_in < 6) begin
        A = op_a[idx_in]; B = op_b[idx_in]; Cin = op_c[idx_in]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("stall in_ready", in_ready, 1'b0);
        chk("stall held output", {out_valid, Cout, Overflow, Zero, Sum}, {1'b1, op_e[idx_out]});
        stall_left--;
      end else if (seen) begin
        chk("stream no bubble", out_valid, 1'b1);
        chk("stream result", {Cout, Overflow, Zero, Sum}, op_e[idx_out]);
        idx_out++;
      end
      in_x = in_valid && in_ready;
      tick();
      if (in_x) idx_in++;
    end
    chk("stream all results", idx_out, 6);
    chk("stream all issued", idx_in, 6);
    in_valid = 1'b0;
    out_ready = 1'b1;
    dup = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) dup = 1'b1;
      tick();
    end
    chk("stream no duplicate", dup, 1'b0);

    // Reset with three operations in flight
    out_ready = 1'b0;
    A = 32'h1111_1111; B = 32'h2222_2222; Cin = 1'b0; in_valid = 1'b1;
    tick();
    A = 32'h0000_0001; B = 32'h0000_0002;
    tick();
    A = 32'h0000_0003; B = 32'h0000_0004;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre-reset held result", {out_valid, Sum}, {1'b1, 32'h3333_3333});
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 1'b0);
    chk("async reset outputs", {Cout, Overflow, Zero, Sum}, 35'd0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) stale = 1'b1;
      tick();
    end
    chk("no stale result", stale, 1'b0);
    chk("in_ready after mid reset", in_ready, 1'b1);
    run_one("post-reset op", 32'h0F0F_0F0F, 32'h00F0_F0F1, 1'b0, {3'b000, 32'h1000_0000});

`ifdef CSEL_ADDER_SUB_EN
    // Subtract mode
    Sub = 1'b1;
    run_one("sub 5-7", 32'h0000_0005, 32'h0000_0007, 1'b0, {3'b000, 32'hFFFF_FFFE});
    run_one("sub min-1", 32'h8000_0000, 32'h0000_0001, 1'b1, {3'b110, 32'h7FFF_FFFF});
    Sub = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
